// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes 6-byte commands, answers with R1, and serves CMD17/CMD24 from byte memory.
// Latency: R1 follows the CRC byte after NCR_BYTES filler bytes; a write strobe fires 1 clk after each data byte is seen.
// Backpressure: none; the host owns sclk, and the card answers at whatever rate it is clocked.
//
// Ports: clk/rst (async active-low); cs/sclk/mosi/miso SPI mode 0 (inputs 2-FF synchronized);
//        mem_addr={block,index[8:0]}, mem_rd_data (1 clk after mem_addr), mem_wr_en/mem_wr_data;
//        card_idle, last_cmd, state_dbg status.
// Build option: define SDR_CRC7_CHECK_EN to verify the command CRC7 (plus end bit) before executing.
module sd_spi_responder #(
  parameter int BLOCK_ADDR_W = 8,
  parameter int NCR_BYTES    = 1,
  parameter int RD_GAP_BYTES = 2,
  parameter int BUSY_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic [BLOCK_ADDR_W+8:0] mem_addr,
  input  logic [7:0]              mem_rd_data,
  output logic                    mem_wr_en,
  output logic [7:0]              mem_wr_data,
  output logic                    card_idle,
  output logic [5:0]              last_cmd,
  output logic [3:0]              state_dbg
);

  typedef enum logic [3:0] {
    WAIT_CMD    = 4'd0,  RECV_CMD = 4'd1,  NCR     = 4'd2,  SEND_R1 = 4'd3,
    RD_GAP      = 4'd4,  RD_TOK   = 4'd5,  RD_DATA = 4'd6,  RD_CRC  = 4'd7,
    WR_WAIT_TOK = 4'd8,  WR_DATA  = 4'd9,  WR_CRC  = 4'd10, WR_RESP = 4'd11,
    WR_BUSY     = 4'd12
  } state_t;

  state_t state, state_nxt;

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_q;
  logic       cs_hi, sclk_rise, sclk_fall, byte_done, load_tx;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte, tx_sr, tx_nxt;
  logic       reload_pend;

  logic [9:0]              cnt;
  logic [5:0]              cmd_q;
  logic [31:0]             arg_q;
  logic [7:0]              r1_q, r1_new;
  logic                    go_rd, go_wr, app_flag;
  logic                    idle_new, app_new, rd_ok, wr_ok, crc_ok;
  logic [BLOCK_ADDR_W-1:0] blk_q;
  logic [8:0]              idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b11;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_q    <= sclk_sync[1];
    end
  end

  // Edges are masked while deselected so a cs rise always wins over a byte completing.
  assign cs_hi     = cs_sync[1];
  assign sclk_rise = ~cs_hi & sclk_sync[1] & ~sclk_q;
  assign sclk_fall = ~cs_hi & ~sclk_sync[1] & sclk_q;
  assign rx_byte   = {rx_sr, mosi_sync[1]};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign load_tx   = sclk_fall & reload_pend;

  always_comb begin
    tx_nxt = 8'hFF;
    case (state)
      SEND_R1: tx_nxt = r1_q;
      RD_TOK:  tx_nxt = 8'hFE;
      RD_DATA: tx_nxt = mem_rd_data;
      WR_RESP: tx_nxt = 8'h05;
      WR_BUSY: tx_nxt = 8'h00;
      default: tx_nxt = 8'hFF;
    endcase
  end

  // Shift engine: sample on rise, drive on fall; the next byte is chosen by the
  // state that the 8th rise moved us into, and loaded on the following fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      tx_sr       <= 8'hFF;
      reload_pend <= 1'b0;
      miso        <= 1'b1;
    end else if (cs_hi) begin
      bit_cnt     <= 3'd0;
      tx_sr       <= 8'hFF;
      reload_pend <= 1'b0;
      miso        <= 1'b1;
    end else begin
      if (sclk_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) reload_pend <= 1'b1;
      end
      if (sclk_fall) begin
        if (reload_pend) begin
          miso        <= tx_nxt[7];
          tx_sr       <= {tx_nxt[6:0], 1'b1};
          reload_pend <= 1'b0;
        end else begin
          miso  <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
    end
  end

`ifdef SDR_CRC7_CHECK_EN
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
`endif

  // Command decode, evaluated while the CRC byte is the received byte.
  always_comb begin
    r1_new   = {7'd0, card_idle} | 8'h04;
    idle_new = card_idle;
    app_new  = 1'b0;
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    crc_ok   = 1'b1;
`ifdef SDR_CRC7_CHECK_EN
    // The end bit must be 1 as well, so a CRC byte with bit0 clear is rejected.
    crc_ok = (rx_byte == {crc7_40({2'b01, cmd_q, arg_q}), 1'b1});
`endif
    if (!crc_ok) begin
      r1_new = {7'd0, card_idle} | 8'h08;
    end else begin
      case (cmd_q)
        6'd0:  begin r1_new = 8'h01; idle_new = 1'b1; end
        6'd1:  begin r1_new = 8'h00; idle_new = 1'b0; end
        6'd55: begin r1_new = {7'd0, card_idle}; app_new = 1'b1; end
        6'd41: if (app_flag) begin r1_new = 8'h00; idle_new = 1'b0; end
        6'd16: r1_new = {7'd0, card_idle};
        6'd17, 6'd24: begin
          if (card_idle)                    r1_new = 8'h05;
          else if (|arg_q[31:BLOCK_ADDR_W]) r1_new = 8'h40;
          else begin
            r1_new = 8'h00;
            rd_ok  = (cmd_q == 6'd17);
            wr_ok  = (cmd_q == 6'd24);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_CMD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_hi) begin
      state_nxt = WAIT_CMD;
    end else if (byte_done) begin
      case (state)
        WAIT_CMD:    if (rx_byte[7:6] == 2'b01) state_nxt = RECV_CMD;
        RECV_CMD:    if (cnt == 10'd4) state_nxt = NCR;
        NCR:         if (cnt == 10'(NCR_BYTES - 1)) state_nxt = SEND_R1;
        SEND_R1:     state_nxt = go_rd ? RD_GAP : (go_wr ? WR_WAIT_TOK : WAIT_CMD);
        RD_GAP:      if (cnt == 10'(RD_GAP_BYTES - 1)) state_nxt = RD_TOK;
        RD_TOK:      state_nxt = RD_DATA;
        RD_DATA:     if (cnt == 10'd512) state_nxt = RD_CRC;
        RD_CRC:      if (cnt == 10'd1) state_nxt = WAIT_CMD;
        WR_WAIT_TOK: if (rx_byte == 8'hFE) state_nxt = WR_DATA;
        WR_DATA:     if (cnt == 10'd511) state_nxt = WR_CRC;
        WR_CRC:      if (cnt == 10'd1) state_nxt = WR_RESP;
        WR_RESP:     state_nxt = WR_BUSY;
        WR_BUSY:     if (cnt == 10'(BUSY_BYTES - 1)) state_nxt = WAIT_CMD;
        default:     state_nxt = WAIT_CMD;
      endcase
    end
  end

  // cnt counts completed bytes in the current state, except in RD_DATA where it
  // counts bytes loaded, so the address for the next byte leads by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 10'd0;
      cmd_q       <= 6'd0;
      arg_q       <= 32'd0;
      r1_q        <= 8'h00;
      go_rd       <= 1'b0;
      go_wr       <= 1'b0;
      app_flag    <= 1'b0;
      card_idle   <= 1'b1;
      last_cmd    <= 6'd0;
      blk_q       <= '0;
      idx_q       <= 9'd0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'h00;
    end else begin
      mem_wr_en <= 1'b0;
      if (cs_hi) begin
        cnt <= 10'd0;
      end else begin
        if (byte_done) begin
          if (state_nxt != state)  cnt <= 10'd0;
          else if (state != RD_DATA) cnt <= cnt + 10'd1;
          case (state)
            WAIT_CMD: if (state_nxt == RECV_CMD) cmd_q <= rx_byte[5:0];
            RECV_CMD: begin
              if (cnt != 10'd4) begin
                arg_q <= {arg_q[23:0], rx_byte};
              end else begin
                last_cmd  <= cmd_q;
                r1_q      <= r1_new;
                card_idle <= idle_new;
                app_flag  <= app_new;
                go_rd     <= rd_ok;
                go_wr     <= wr_ok;
                blk_q     <= arg_q[BLOCK_ADDR_W-1:0];
                idx_q     <= 9'd0;
              end
            end
            WR_DATA: begin
              mem_wr_en   <= 1'b1;
              mem_wr_data <= rx_byte;
              idx_q       <= cnt[8:0];
            end
            default: ;
          endcase
        end
        if (load_tx && state == RD_DATA) begin
          cnt <= cnt + 10'd1;
          if (cnt != 10'd511) idx_q <= cnt[8:0] + 9'd1;
        end
      end
    end
  end

  assign mem_addr  = {blk_q, idx_q};
  assign state_dbg = state;

endmodule
